// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Shares one synchronous single-port framebuffer RAM between the scanout
// prefetcher (which fills a show-ahead pixel FIFO) and the host requester.
// Scanout takes the port when its FIFO level is at or below LOW_WM. Otherwise
// contested cycles alternate between the two sides.
//
// Ports
//   clk, n_rst          clock, asynchronous active-low reset
//   frame_start         restart scanout at FB_BASE and flush the FIFO
//   pix_rd              pop the FIFO head
//   pix_valid/pix_data  show-ahead FIFO head
//   underrun            sticky flag for a pop while empty, cleared by frame_start
//   host_req/we/addr/wdata  host access request, held until host_gnt
//   host_gnt            host access issued to memory this cycle
//   host_rvalid/rdata   host read response, one cycle after the grant
//   mem_req/we/addr/wdata   memory command, combinational
//   mem_rdata           memory read data, one cycle after a read
//
// state | meaning
// IDLE  | after reset, no scanout fetches, host only
// FETCH | fetching frame words fp = 0 .. FB_WORDS-1
// DONE  | last frame word fetched, host only until next frame_start
module vga_fb_arbiter #(
   parameter int AW       = 16,
   parameter int DW       = 32,
   parameter int FB_BASE  = 0,
   parameter int FB_WORDS = 38400,
   parameter int DEPTH    = 8,
   parameter int LOW_WM   = 2
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          frame_start,
   input  logic          pix_rd,
   output logic          pix_valid,
   output logic [DW-1:0] pix_data,
   output logic          underrun,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_gnt,
   output logic          host_rvalid,
   output logic [DW-1:0] host_rdata,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int FPW = (FB_WORDS > 1) ? $clog2(FB_WORDS) : 1;
   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OW  = $clog2(DEPTH + 1);
   localparam logic [FPW-1:0] FP_LAST = FPW'(FB_WORDS - 1);
   localparam logic [OW:0]    DEPTH_C = (OW+1)'(DEPTH);
   localparam logic [OW:0]    LOW_C   = (OW+1)'(LOW_WM);

   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

   state_t          state;
   logic [FPW-1:0]  fp;
   logic [OW-1:0]   occ;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [DW-1:0]   fifo [DEPTH];
   logic            inflight_q;
   logic            inflight_epoch;
   logic            epoch;
   logic            last_fetch;
   logic            host_rd_q;

   logic [OW:0]     level;
   logic            fetch_elig;
   logic            urgent;
   logic            fetch_win;
   logic            host_win;
   logic            contest;
   logic            push;
   logic            pop;
   logic [31:0]     fetch_addr;

   // Level counts the read still in flight so the FIFO can never overflow.
   assign level      = {1'b0, occ} + {{OW{1'b0}}, inflight_q};
   assign fetch_elig = (state == FETCH) && (level < DEPTH_C);
   assign urgent     = fetch_elig && (level <= LOW_C);
   assign contest    = fetch_elig && host_req && !urgent;
   assign fetch_win  = fetch_elig && (urgent || !host_req || !last_fetch);
   assign host_win   = host_req && !fetch_win;
   assign fetch_addr = 32'(FB_BASE) + 32'(fp);

   assign mem_req   = fetch_win || host_win;
   assign mem_we    = host_win && host_we;
   assign mem_addr  = fetch_win ? fetch_addr[AW-1:0] : (host_win ? host_addr : '0);
   assign mem_wdata = host_win ? host_wdata : '0;

   assign host_gnt    = host_win;
   assign host_rvalid = host_rd_q;
   assign host_rdata  = host_rd_q ? mem_rdata : '0;

   // A read issued before the latest frame_start carries the old epoch and is dropped.
   assign push = inflight_q && (inflight_epoch == epoch);
   assign pop  = pix_rd && (occ != '0);

   assign pix_valid = (occ != '0);
   assign pix_data  = fifo[rd_ptr];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state          <= IDLE;
         fp             <= '0;
         occ            <= '0;
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         inflight_q     <= 1'b0;
         inflight_epoch <= 1'b0;
         epoch          <= 1'b0;
         last_fetch     <= 1'b0;
         host_rd_q      <= 1'b0;
         underrun       <= 1'b0;
         for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
      end else begin
         inflight_q     <= fetch_win;
         inflight_epoch <= epoch;
         host_rd_q      <= host_win && !host_we;
         if (contest) last_fetch <= fetch_win;

         if (frame_start) begin
            state    <= FETCH;
            fp       <= '0;
            epoch    <= ~epoch;
            occ      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            underrun <= 1'b0;
         end else begin
            if (fetch_win) begin
               if (fp == FP_LAST) state <= DONE;
               else               fp    <= fp + 1'b1;
            end
            if (push) begin
               fifo[wr_ptr] <= mem_rdata;
               wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      occ <= occ + 1'b1;
            else if (pop && !push) occ <= occ - 1'b1;
            if (pix_rd && (occ == '0)) underrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter. Instance a uses the full-size frame,
// instance b uses a 4-word frame to reach the end-of-frame and restart cases.
// Each instance has its own synchronous RAM model with one-cycle read latency.
module tb_vga_fb_arbiter;

   logic clk = 1'b0;
   logic n_rst;
   always #5 clk = ~clk;

   logic        frame_start_a, pix_rd_a, pix_valid_a, underrun_a;
   logic [31:0] pix_data_a;
   logic        host_req_a, host_we_a, host_gnt_a, host_rvalid_a;
   logic [15:0] host_addr_a;
   logic [31:0] host_wdata_a, host_rdata_a;
   logic        mem_req_a, mem_we_a;
   logic [15:0] mem_addr_a;
   logic [31:0] mem_wdata_a, mem_rdata_a;

   logic        frame_start_b, pix_rd_b, pix_valid_b, underrun_b;
   logic [31:0] pix_data_b;
   logic        host_req_b, host_we_b, host_gnt_b, host_rvalid_b;
   logic [15:0] host_addr_b;
   logic [31:0] host_wdata_b, host_rdata_b;
   logic        mem_req_b, mem_we_b;
   logic [15:0] mem_addr_b;
   logic [31:0] mem_wdata_b, mem_rdata_b;

   vga_fb_arbiter u_dut_a (
      .clk(clk), .n_rst(n_rst), .frame_start(frame_start_a), .pix_rd(pix_rd_a),
      .pix_valid(pix_valid_a), .pix_data(pix_data_a), .underrun(underrun_a),
      .host_req(host_req_a), .host_we(host_we_a), .host_addr(host_addr_a),
      .host_wdata(host_wdata_a), .host_gnt(host_gnt_a), .host_rvalid(host_rvalid_a),
      .host_rdata(host_rdata_a), .mem_req(mem_req_a), .mem_we(mem_we_a),
      .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
   );

   vga_fb_arbiter #(.FB_WORDS(4)) u_dut_b (
      .clk(clk), .n_rst(n_rst), .frame_start(frame_start_b), .pix_rd(pix_rd_b),
      .pix_valid(pix_valid_b), .pix_data(pix_data_b), .underrun(underrun_b),
      .host_req(host_req_b), .host_we(host_we_b), .host_addr(host_addr_b),
      .host_wdata(host_wdata_b), .host_gnt(host_gnt_b), .host_rvalid(host_rvalid_b),
      .host_rdata(host_rdata_b), .mem_req(mem_req_b), .mem_we(mem_we_b),
      .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
   );

   function automatic logic [31:0] word_a(input int i);
      return (i == 42) ? 32'hDEAD_BEEF : 32'hA000_0000 + 32'(i);
   endfunction

   function automatic logic [31:0] word_b(input int i);
      return 32'hB000_0000 + 32'(i);
   endfunction

   logic [31:0] ram_a [512];
   logic [31:0] ram_b [512];

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < 512; i++) ram_a[i] <= word_a(i);
         mem_rdata_a <= '0;
      end else if (mem_req_a) begin
         if (mem_we_a) ram_a[mem_addr_a[8:0]] <= mem_wdata_a;
         else          mem_rdata_a <= ram_a[mem_addr_a[8:0]];
      end
   end

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < 512; i++) ram_b[i] <= word_b(i);
         mem_rdata_b <= '0;
      end else if (mem_req_b) begin
         if (mem_we_b) ram_b[mem_addr_b[8:0]] <= mem_wdata_b;
         else          mem_rdata_b <= ram_b[mem_addr_b[8:0]];
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int exp_gnt2 [12] = '{1, 0, 1, 1, 1, 1, 0, 1, 1, 1, 0, 1};
   int exp_fa2  [12] = '{0, 8, 0, 0, 0, 0, 9, 0, 0, 0, 10, 0};
   int exp_gnt4 [5]  = '{0, 0, 0, 1, 0};
   int exp_adr4 [5]  = '{0, 1, 2, 'h101, 3};

   initial begin
      n_rst = 1'b0;
      frame_start_a = 0; pix_rd_a = 0; host_req_a = 0; host_we_a = 0;
      host_addr_a = '0; host_wdata_a = '0;
      frame_start_b = 0; pix_rd_b = 0; host_req_b = 0; host_we_b = 0;
      host_addr_b = '0; host_wdata_b = '0;

      #12;
      chk("rst_pix_valid", 32'(pix_valid_a), 0);
      chk("rst_pix_data", pix_data_a, 0);
      chk("rst_underrun", 32'(underrun_a), 0);
      chk("rst_mem_req", 32'(mem_req_a), 0);
      chk("rst_host_rvalid", 32'(host_rvalid_a), 0);
      chk("rst_underrun_b", 32'(underrun_b), 0);
      n_rst = 1'b1;

      // Frame start, no pops: eight back-to-back fetches at 0..7, then full.
      tick();
      frame_start_a = 1;
      #1;
      chk("idle_no_fetch", 32'(mem_req_a), 0);
      tick();
      frame_start_a = 0;
      for (int k = 0; k < 9; k++) begin
         #1;
         chk("fill_mem_req", 32'(mem_req_a), (k < 8) ? 1 : 0);
         if (k < 8) chk("fill_addr", 32'(mem_addr_a), 32'(k));
         chk("fill_pix_valid", 32'(pix_valid_a), (k >= 2) ? 1 : 0);
         tick();
      end
      #1;
      chk("full_no_fetch", 32'(mem_req_a), 0);
      chk("full_pix_valid", 32'(pix_valid_a), 1);
      chk("full_pix_data", pix_data_a, word_a(0));

      // Full FIFO, host writes held, pop every 4 cycles.
      for (int j = 0; j < 12; j++) begin
         tick();
         host_req_a = 1; host_we_a = 1; host_addr_a = 16'h0100;
         host_wdata_a = 32'h5000_0000 + 32'(j);
         pix_rd_a = (j % 4 == 0);
         #1;
         chk("rr_host_gnt", 32'(host_gnt_a), 32'(exp_gnt2[j]));
         chk("rr_mem_req", 32'(mem_req_a), 1);
         if (exp_gnt2[j] == 1) begin
            chk("rr_host_we", 32'(mem_we_a), 1);
            chk("rr_host_addr", 32'(mem_addr_a), 32'h100);
            chk("rr_host_wdata", mem_wdata_a, 32'h5000_0000 + 32'(j));
         end else begin
            chk("rr_fetch_we", 32'(mem_we_a), 0);
            chk("rr_fetch_addr", 32'(mem_addr_a), 32'(exp_fa2[j]));
         end
         if (j % 4 == 0) chk("rr_pop_data", pix_data_a, word_a(j / 4));
      end
      tick();
      host_req_a = 0; host_we_a = 0; pix_rd_a = 0;

      // Host read of 0x2A.
      tick();
      host_req_a = 1; host_we_a = 0; host_addr_a = 16'h002A;
      #1;
      chk("rd_gnt", 32'(host_gnt_a), 1);
      chk("rd_we", 32'(mem_we_a), 0);
      chk("rd_addr", 32'(mem_addr_a), 32'h2A);
      tick();
      host_req_a = 0;
      #1;
      chk("rd_rvalid", 32'(host_rvalid_a), 1);
      chk("rd_rdata", host_rdata_a, 32'hDEAD_BEEF);
      tick();
      chk("rd_rvalid_drop", 32'(host_rvalid_a), 0);

      // Urgent fetch after a flush beats a held host request.
      tick();
      frame_start_a = 1; host_req_a = 1; host_we_a = 1;
      host_addr_a = 16'h0101; host_wdata_a = 32'h0000_0077;
      #1;
      chk("urg_gnt_full", 32'(host_gnt_a), 1);
      tick();
      frame_start_a = 0;
      #1;
      chk("urg_flushed", 32'(pix_valid_a), 0);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) tick();
         #1;
         chk("urg_gnt", 32'(host_gnt_a), 32'(exp_gnt4[k]));
         chk("urg_addr", 32'(mem_addr_a), 32'(exp_adr4[k]));
         if (k == 2) chk("urg_first_pix", pix_data_a, word_a(0));
      end
      tick();
      host_req_a = 0; host_we_a = 0;

      // Instance b: pop while empty sets a sticky underrun.
      pix_rd_b = 1;
      #1;
      chk("ur_valid", 32'(pix_valid_b), 0);
      tick();
      pix_rd_b = 0;
      #1;
      chk("ur_set", 32'(underrun_b), 1);
      repeat (3) tick();
      chk("ur_sticky", 32'(underrun_b), 1);

      // Frame start with a pop: flush wins. Then pop through a 4-word frame.
      frame_start_b = 1; pix_rd_b = 1;
      #1;
      chk("b_idle", 32'(mem_req_b), 0);
      tick();
      frame_start_b = 0;
      #1;
      chk("b_ur_clear", 32'(underrun_b), 0);
      chk("b_f1_addr", 32'(mem_addr_b), 0);
      tick();
      chk("b_ur_reset", 32'(underrun_b), 1);
      chk("b_f2_addr", 32'(mem_addr_b), 1);
      tick();
      chk("b_f3_valid", 32'(pix_valid_b), 1);
      chk("b_f3_data", pix_data_b, word_b(0));
      chk("b_f3_addr", 32'(mem_addr_b), 2);
      tick();
      chk("b_f4_data", pix_data_b, word_b(1));
      chk("b_f4_addr", 32'(mem_addr_b), 3);
      chk("b_f4_req", 32'(mem_req_b), 1);
      tick();
      chk("b_done_req", 32'(mem_req_b), 0);
      chk("b_f5_data", pix_data_b, word_b(2));
      tick();
      chk("b_f6_data", pix_data_b, word_b(3));
      chk("b_f6_req", 32'(mem_req_b), 0);
      tick();
      pix_rd_b = 0;
      #1;
      chk("b_f7_empty", 32'(pix_valid_b), 0);

      // Restart, then restart again while a fetch is in flight.
      frame_start_b = 1;
      tick();
      frame_start_b = 0;
      #1;
      chk("b_g1_addr", 32'(mem_addr_b), 0);
      tick();
      tick();
      frame_start_b = 1;
      #1;
      chk("b_g3_req", 32'(mem_req_b), 1);
      chk("b_g3_addr", 32'(mem_addr_b), 2);
      tick();
      frame_start_b = 0;
      #1;
      chk("b_g4_addr", 32'(mem_addr_b), 0);
      chk("b_g4_empty", 32'(pix_valid_b), 0);
      tick();
      chk("b_stale_dropped", 32'(pix_valid_b), 0);
      tick();
      chk("b_g6_valid", 32'(pix_valid_b), 1);
      chk("b_g6_data", pix_data_b, word_b(0));

      // Reset mid-operation drops a pending host read response.
      repeat (10) tick();
      host_req_a = 1; host_we_a = 0; host_addr_a = 16'h002A;
      #1;
      chk("mr_gnt", 32'(host_gnt_a), 1);
      tick();
      host_req_a = 0;
      n_rst = 1'b0;
      #1;
      chk("mr_rvalid", 32'(host_rvalid_a), 0);
      chk("mr_rdata", host_rdata_a, 0);
      chk("mr_pix_valid", 32'(pix_valid_a), 0);
      chk("mr_pix_valid_b", 32'(pix_valid_b), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
